tone_decoder: RTL and testbench
===============================

Name: tone_decoder

Overview:
- Receive-side counterpart of the F_CODE/SPKER tone path: measures the period of an incoming SPKS square wave and recovers the divider preset, note index and high-octave flag.
- Used for loop-back self-test of the music player (SPKER.SPKS -> tone_decoder) and as a note-recognition front end.
- Runs on the same fast clock as SPKER.

Parameters:
- CNT_W, 13: period counter width; covers the maximum tone period of 4096 cycles.
- TOL, 2: maximum allowed |TN_meas - NOTE_TN[i]| for a table match.
- LOCK_N, 3: consecutive identical matches required to assert LOCK.
- TIMEOUT, 4200: cycles without a SPKS rising edge before the input is declared silent.

Ports:
- CLK  in  1  system clock (same domain as SPKER).
- RST_N  in  1  reset; asynchronous, active-low.
- SPKS  in  1  tone square wave; asynchronous to CLK.
- TN_OUT  out  11  measured divider preset.
- INX_OUT  out  4  decoded note index.
- H  out  1  high-octave flag of the decoded note.
- VALID  out  1  one-cycle pulse when a new decode result is written.
- LOCK  out  1  LOCK_N consecutive identical INX decodes seen.
- SILENT  out  1  no SPKS edge for TIMEOUT cycles.
- ERR  out  1  last measured period matched no table entry.
- OVR  out  1  sticky; a period was discarded because the lookup was busy.

Behaviour:
- Reset (async, RST_N=0): all outputs 0; FSM = IDLE; counters and synchronizer cleared. Reset mid-lookup abandons the lookup with no VALID.
- SPKS front end:
  - 2-flop synchronizer plus a delay flop.
  - rise = sync & ~dly.
- Period counter:
  - Counts CLK cycles. On rise, P = count+1 is captured and the counter restarts at 0.
  - Saturates at TIMEOUT. At saturation: SILENT=1, LOCK=0, lock count=0, FSM -> IDLE.
- Tone model: SPKER full period is 2*(2048-TN) cycles, so TN_meas = 2048 - (P>>1), 11-bit.
- Rest handling: P<=3 is treated as TN_meas=2047 (rest).
- FSM states:
  - IDLE: wait for the first rise after reset or silence. That rise only starts timing (no capture); clear SILENT -> ARMED.
  - ARMED: on rise, capture P, compute TN_meas, i=0 -> LOOKUP.
  - LOOKUP: one table entry per cycle, i = 0..15.
    - First i with |TN_meas - NOTE_TN[i]| <= TOL wins. Ties resolve to the lowest i.
    - On a win: go to REPORT.
    - At i=15 with no match: go to REPORT with nomatch=1.
  - REPORT, one cycle:
    - TN_OUT = TN_meas.
    - On a match: INX_OUT = i, H = NOTE_H[i], ERR = 0.
    - On nomatch: INX_OUT and H are held, ERR = 1.
    - VALID = 1.
    - Lock counter:
      - A match with INX equal to the previous match increments it, saturating at LOCK_N.
      - A different match sets it to 1.
      - nomatch sets it to 0.
    - LOCK = (counter == LOCK_N).
    - Then -> ARMED.
- Latency: rise (synchronized) to VALID is 2..17 cycles (capture + 1..16 lookup cycles + report).
- Busy rule: a rise during LOOKUP/REPORT still restarts the period counter, but that period is dropped and OVR=1 (sticky until reset).
- The timeout check has priority over a rise in the same cycle.
- Outputs are held between VALID pulses.

Decomposition:
- Package tone_pkg holds:
  - NOTE_TN[0:15] (11-bit presets, index 0 = 2047 rest), NOTE_H[0:15]. F_CODE is refactored to read the same constants.
  - SPK_CNT_MAX = 2047, the FSM state enum, TN_W = 11.
- Sub-module tone_period_meter: synchronizer, edge detect, period counter, timeout. Outputs rise, P, timeout.
- FSM, lookup and lock logic live in the top.

Test Plan:
- Drive SPKER with TN = NOTE_TN[5] for 5 periods:
  - VALID pulses with TN_OUT = NOTE_TN[5], INX_OUT = 5, H = NOTE_H[5].
  - LOCK=1 after the 3rd decode.
  - ERR=0, OVR=0.
- Switch TN from NOTE_TN[5] to NOTE_TN[12] mid-tone: first new decode shows INX=12 and LOCK=0; LOCK returns after 3 decodes.
- Square wave with P = 2*(2048-(NOTE_TN[3]+2)) (within TOL): INX_OUT=3, TN_OUT = NOTE_TN[3]+2. Then offset +5: ERR=1 with INX_OUT held and LOCK=0.
- Stop SPKS for 4200 cycles: SILENT=1, LOCK=0, no VALID. On restart, the first rise gives no VALID and the second rise gives VALID.
- Inject a rise 4 cycles after capture (during LOOKUP): OVR=1. The in-flight result still reports and the dropped period produces no VALID.
- Pulse RST_N low for 1 ns during LOOKUP (async, between edges): all outputs 0 immediately, no VALID afterwards, FSM in IDLE.

Source files
------------

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared note table, tone widths and decoder state type
package tone_pkg;

  localparam int TN_W        = 11;
  localparam int SPK_CNT_MAX = 2047;

  // Divider presets shared with F_CODE; index 0 is the rest preset.
  localparam logic [TN_W-1:0] NOTE_TN [0:15] = '{
    11'd2047, 11'd773,  11'd912,  11'd1036, 11'd1116, 11'd1197, 11'd1290, 11'd1372,
    11'd1410, 11'd1480, 11'd1542, 11'd1622, 11'd1668, 11'd1728, 11'd1774, 11'd1807
  };

  localparam logic NOTE_H [0:15] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LOOKUP,
    ST_REPORT
  } state_t;

  function automatic logic [TN_W-1:0] tn_abs_diff(input logic [TN_W-1:0] a,
                                                  input logic [TN_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/tone_decoder_if.sv
// rtl/tone_decoder_if.sv - SPKS input and decode result bundle
interface tone_decoder_if;
  import tone_pkg::*;

  logic            spks;
  logic [TN_W-1:0] tn_out;
  logic [3:0]      inx_out;
  logic            h;
  logic            valid;
  logic            lock;
  logic            silent;
  logic            err;
  logic            ovr;

  modport master (output spks,
                  input  tn_out, inx_out, h, valid, lock, silent, err, ovr);
  modport slave  (input  spks,
                  output tn_out, inx_out, h, valid, lock, silent, err, ovr);

endinterface

// File: rtl/tone_period_meter.sv
// rtl/tone_period_meter.sv - SPKS synchronizer, rising-edge detect and period counter
module tone_period_meter #(
  parameter int CNT_W   = 13,
  parameter int TIMEOUT = 4200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spks,
  output logic             rise,
  output logic [CNT_W-1:0] period,
  output logic             timeout
);

  logic             s1;
  logic             s2;
  logic             dly;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      dly <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= spks;
      s2  <= s1;
      dly <= s2;
      if (rise)
        cnt <= '0;
      else if (cnt != CNT_W'(TIMEOUT))
        cnt <= cnt + 1'b1;
    end
  end

  assign rise    = s2 & ~dly;
  assign period  = cnt + 1'b1;
  // One-cycle event on the step into saturation, so a rise after silence is not swallowed.
  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - recovers divider preset, note index and octave from the SPKS period
module tone_decoder
  import tone_pkg::*;
#(
  parameter int CNT_W   = 13,
  parameter int TOL     = 2,
  parameter int LOCK_N  = 3,
  parameter int TIMEOUT = 4200
) (
  input  logic           clk,
  input  logic           rst_n,
  tone_decoder_if.slave  bus
);

  localparam int LC_W = $clog2(LOCK_N + 1);

  logic             rise;
  logic             timeout;
  logic [CNT_W-1:0] period;
  state_t           state;
  logic [TN_W-1:0]  tn_meas;
  logic [TN_W-1:0]  tn_calc;
  logic [3:0]       idx;
  logic [LC_W-1:0]  lock_cnt;
  logic [LC_W-1:0]  lc_next;
  logic             hit;

  tone_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .clk     (clk),
    .rst_n   (rst_n),
    .spks    (bus.spks),
    .rise    (rise),
    .period  (period),
    .timeout (timeout)
  );

  // Full SPKS period is 2*(2048-TN); very short periods decode as the rest preset.
  always_comb begin
    tn_calc = TN_W'(CNT_W'(SPK_CNT_MAX + 1) - (period >> 1));
    if (period <= CNT_W'(3))
      tn_calc = TN_W'(SPK_CNT_MAX);
  end

  assign hit = (tn_abs_diff(tn_meas, NOTE_TN[idx]) <= TN_W'(TOL));

  always_comb begin
    lc_next = LC_W'(1);
    if (idx == bus.inx_out) begin
      if (lock_cnt != LC_W'(LOCK_N))
        lc_next = lock_cnt + 1'b1;
      else
        lc_next = lock_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tn_meas     <= '0;
      idx         <= '0;
      lock_cnt    <= '0;
      bus.tn_out  <= '0;
      bus.inx_out <= '0;
      bus.h       <= 1'b0;
      bus.valid   <= 1'b0;
      bus.lock    <= 1'b0;
      bus.silent  <= 1'b0;
      bus.err     <= 1'b0;
      bus.ovr     <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (timeout) begin
        bus.silent <= 1'b1;
        bus.lock   <= 1'b0;
        lock_cnt   <= '0;
        state      <= ST_IDLE;
      end else begin
        if (rise && (state == ST_LOOKUP || state == ST_REPORT))
          bus.ovr <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (rise) begin
              bus.silent <= 1'b0;
              state      <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (rise) begin
              tn_meas <= tn_calc;
              idx     <= '0;
              state   <= ST_LOOKUP;
            end
          end
          ST_LOOKUP: begin
            // Result registers load on the last lookup cycle so VALID is high in REPORT.
            if (hit) begin
              bus.tn_out  <= tn_meas;
              bus.inx_out <= idx;
              bus.h       <= NOTE_H[idx];
              bus.err     <= 1'b0;
              bus.valid   <= 1'b1;
              lock_cnt    <= lc_next;
              bus.lock    <= (lc_next == LC_W'(LOCK_N));
              state       <= ST_REPORT;
            end else if (idx == 4'd15) begin
              bus.tn_out <= tn_meas;
              bus.err    <= 1'b1;
              bus.valid  <= 1'b1;
              lock_cnt   <= '0;
              bus.lock   <= 1'b0;
              state      <= ST_REPORT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          ST_REPORT: state <= ST_ARMED;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - randomized and directed bench for tone_decoder against an event-level model
module tb_tone_decoder;
  import tone_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tone_decoder_if bus();

  tone_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rst_pulsed = 1'b0;

  // Model state: times are clock-edge indices.
  int last_rise, busy_end, rep_edge, p_tn, p_k, e_lc;
  bit active, h1, h2, h3;
  logic        e_valid, e_lock, e_silent, e_ovr, e_err, e_h;
  logic [3:0]  e_inx;
  logic [10:0] e_tn;

  task automatic finish_tb;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset(input int edge_idx);
    last_rise = edge_idx;
    busy_end = -1; rep_edge = -1; p_tn = 0; p_k = -1; e_lc = 0;
    active = 0; h1 = 0; h2 = 0; h3 = 0;
    e_valid = 0; e_lock = 0; e_silent = 0; e_ovr = 0; e_err = 0; e_h = 0;
    e_inx = '0; e_tn = '0;
  endtask

  task automatic model_capture(input int p);
    int tn, k, d, nl;
    tn = (p <= 3) ? 2047 : ((2048 - p / 2) & 2047);
    k = -1;
    for (int i = 0; i < 16; i++) begin
      d = tn - int'(NOTE_TN[i]);
      if (d < 0) d = -d;
      if (k < 0 && d <= 2) k = i;
    end
    nl = (k < 0) ? 15 : k;
    p_tn = tn; p_k = k;
    rep_edge = cyc + 1 + nl;
    busy_end = cyc + 2 + nl;
  endtask

  task automatic model_edge(input logic s);
    bit r;
    r = h2 && !h3;
    h3 = h2; h2 = h1; h1 = s;
    e_valid = 0;
    if (rep_edge == cyc) begin
      e_valid = 1;
      e_tn = 11'(p_tn);
      if (p_k >= 0) begin
        e_lc = (p_k == int'(e_inx)) ? ((e_lc < 3) ? e_lc + 1 : 3) : 1;
        e_inx = 4'(p_k);
        e_h = NOTE_H[p_k];
        e_err = 0;
      end else begin
        e_lc = 0;
        e_err = 1;
      end
      e_lock = (e_lc == 3);
    end
    if (cyc - last_rise == 4200) begin
      e_silent = 1; e_lc = 0; e_lock = 0; active = 0;
    end else if (r) begin
      if (!active) begin
        active = 1; e_silent = 0;
      end else if (cyc <= busy_end) begin
        e_ovr = 1;
      end else begin
        model_capture(cyc - last_rise);
      end
    end
    if (r) last_rise = cyc;
  endtask

  // Per-cycle compare of every output against the model.
  initial begin
    logic [20:0] act_v, exp_v;
    model_reset(0);
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset(cyc);
      else        model_edge(bus.spks);
      @(negedge clk);
      if (rst_pulsed) begin
        rst_pulsed = 0;
        model_reset(cyc);
      end
      if (rst_n) begin
        act_v = {bus.valid, bus.lock, bus.silent, bus.ovr, bus.err, bus.h, bus.inx_out, bus.tn_out};
        exp_v = {e_valid, e_lock, e_silent, e_ovr, e_err, e_h, e_inx, e_tn};
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL outputs@%0d got=%h exp=%h (valid,lock,silent,ovr,err,h,inx,tn)",
                   cyc, act_v, exp_v);
          if (n_fail >= 200) finish_tb();
        end
      end
    end
  end

  task automatic period_run(input int p);
    int hi;
    hi = p / 2;
    if (hi < 1) hi = 1;
    bus.spks = 1'b1;
    repeat (hi) @(negedge clk);
    bus.spks = 1'b0;
    repeat (p - hi) @(negedge clk);
  endtask

  task automatic tone(input int tn, input int n);
    repeat (n) period_run(2 * (2048 - tn));
  endtask

  initial begin
    int p, ni, off;
    bus.spks = 1'b0;
    repeat (3) @(negedge clk);
    check_lit("reset_outputs",
              int'({bus.valid, bus.lock, bus.silent, bus.ovr, bus.err, bus.h, bus.inx_out, bus.tn_out}), 0);
    rst_n = 1'b1;

    tone(1197, 6);
    check_lit("n5_inx", int'(bus.inx_out), 5);
    check_lit("n5_tn", int'(bus.tn_out), 1197);
    check_lit("n5_h", int'(bus.h), 0);
    check_lit("n5_lock", int'(bus.lock), 1);
    check_lit("n5_err", int'(bus.err), 0);
    check_lit("n5_ovr", int'(bus.ovr), 0);

    tone(1668, 2);
    check_lit("n12_first_inx", int'(bus.inx_out), 12);
    check_lit("n12_first_lock", int'(bus.lock), 0);
    check_lit("n12_h", int'(bus.h), 1);
    tone(1668, 3);
    check_lit("n12_relock", int'(bus.lock), 1);

    repeat (3) period_run(2020);
    check_lit("tol_inx", int'(bus.inx_out), 3);
    check_lit("tol_tn", int'(bus.tn_out), 1038);
    check_lit("tol_err", int'(bus.err), 0);
    repeat (2) period_run(2014);
    check_lit("off5_err", int'(bus.err), 1);
    check_lit("off5_inx_held", int'(bus.inx_out), 3);
    check_lit("off5_tn", int'(bus.tn_out), 1041);
    check_lit("off5_lock", int'(bus.lock), 0);

    repeat (4400) @(negedge clk);
    check_lit("silence_silent", int'(bus.silent), 1);
    check_lit("silence_lock", int'(bus.lock), 0);
    repeat (3) period_run(760);
    check_lit("restart_silent", int'(bus.silent), 0);
    check_lit("restart_inx", int'(bus.inx_out), 12);

    // Extra rise four cycles after a capture lands in LOOKUP.
    bus.spks = 1'b1; repeat (3) @(negedge clk);
    bus.spks = 1'b0; @(negedge clk);
    bus.spks = 1'b1; repeat (378) @(negedge clk);
    bus.spks = 1'b0; repeat (378) @(negedge clk);
    repeat (2) period_run(760);
    check_lit("busy_ovr", int'(bus.ovr), 1);
    check_lit("busy_inx", int'(bus.inx_out), 12);

    // Short asynchronous reset while a lookup is running.
    bus.spks = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_lit("async_reset_outputs",
                 int'({bus.valid, bus.lock, bus.silent, bus.ovr, bus.err, bus.h, bus.inx_out, bus.tn_out}), 0);
    rst_n = 1'b1;
    rst_pulsed = 1'b1;
    @(negedge clk);
    repeat (300) @(negedge clk);
    bus.spks = 1'b0;
    repeat (380) @(negedge clk);
    repeat (3) period_run(760);

    repeat (20) begin
      if ($urandom_range(0, 5) == 0) begin
        p = $urandom_range(2, 40);
      end else begin
        ni  = $urandom_range(1, 15);
        off = $urandom_range(0, 8) - 4;
        p   = 2 * (2048 - int'(NOTE_TN[ni]) - off) + $urandom_range(0, 1);
      end
      period_run(p);
    end
    repeat (20) @(negedge clk);
    finish_tb();
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    finish_tb();
  end

endmodule
